// File: rtl/decryption_if.sv
// rtl/decryption_if.sv - cipher-in / plaintext-out bundle for decryption; byte_cnt exists only with DECRYPT_CNT_EN
interface decryption_if #(
  parameter int N = 8
`ifdef DECRYPT_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [N-1:0]     din;
  logic             vin;
  logic [1:0]       direction;
  logic [4:0]       shift;
  logic             resync;
  logic [N-1:0]     dout;
  logic             v;
`ifdef DECRYPT_CNT_EN
  logic [CNT_W-1:0] byte_cnt;
`endif

  // Upstream side: supplies cipher bytes and sideband, observes plaintext.
  modport master (
    output din, vin, direction, shift, resync,
    input  dout, v
`ifdef DECRYPT_CNT_EN
    , input byte_cnt
`endif
  );

  // Decryption side.
  modport slave (
    input  din, vin, direction, shift, resync,
    output dout, v
`ifdef DECRYPT_CNT_EN
    , output byte_cnt
`endif
  );
endinterface

// File: rtl/decryption.sv
// rtl/decryption.sv - 3-stage cipher-byte decryptor (key XOR, inverse permute, inverse Caesar); DECRYPT_CNT_EN adds byte_cnt
module decryption #(
  parameter int         N  = 8,
  parameter logic [N-1:0] K1 = 8'b0011_1110,
  parameter logic [N-1:0] K2 = 8'b0100_1001,
  parameter logic [N-1:0] K3 = 8'b0111_1110
`ifdef DECRYPT_CNT_EN
  , parameter int       CNT_W = 16
`endif
) (
  input logic         clock,
  input logic         rst,
  decryption_if.slave bus
);

  typedef enum logic [1:0] {
    KEY0 = 2'd0,
    KEY1 = 2'd1,
    KEY2 = 2'd2
  } key_idx_e;

  localparam logic [N:0]   UP_LO = 'h41;
  localparam logic [N:0]   UP_HI = 'h5A;
  localparam logic [N:0]   LO_LO = 'h61;
  localparam logic [N:0]   LO_HI = 'h7A;
  localparam logic [N-1:0] WRAP  = 'd26;

  key_idx_e     idx_q, idx_d;
  logic [N-1:0] key;
  logic [4:0]   sh_mod;

  logic         s1_v_q;
  logic [N-1:0] s1_x_q;
  logic [1:0]   s1_dir_q;
  logic [4:0]   s1_sh_q;
  logic [N-1:0] perm;

  logic         s2_v_q;
  logic [N-1:0] s2_p_q;
  logic [1:0]   s2_dir_q;
  logic [4:0]   s2_sh_q;

  logic [N:0]   p_w, s_w, sum_w, diff_w;
  logic [N-1:0] s_n;
  logic         is_up, is_lo;
  logic [N-1:0] dout_d;

  logic [N-1:0] dout_q;
  logic         v_q;

  // Key index register: only moves on accepted bytes or resync.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) idx_q <= KEY0;
    else      idx_q <= idx_d;
  end

  // Key selection and next index; a resync byte is forced onto K1 and the next byte uses K2.
  always_comb begin
    idx_d = idx_q;
    key   = K1;
    if (bus.resync) begin
      key   = K1;
      idx_d = bus.vin ? KEY1 : KEY0;
    end else begin
      case (idx_q)
        KEY0:    key = K1;
        KEY1:    key = K2;
        default: key = K3;
      endcase
      if (bus.vin) begin
        case (idx_q)
          KEY0:    idx_d = KEY1;
          KEY1:    idx_d = KEY2;
          default: idx_d = KEY0;
        endcase
      end
    end
  end

  // Reduce shift to 0..25 once, at capture, so later stages never see the raw value.
  always_comb begin
    sh_mod = (bus.shift >= 5'd26) ? bus.shift - 5'd26 : bus.shift;
    perm   = {s1_x_q[3], s1_x_q[4], s1_x_q[6], s1_x_q[2],
              s1_x_q[1], s1_x_q[5], s1_x_q[0], s1_x_q[7]};
  end

  // Inverse Caesar on the permuted byte; compares run in N+1 bits so the bounds are exact.
  always_comb begin
    p_w    = {1'b0, s2_p_q};
    s_n    = {{(N-5){1'b0}}, s2_sh_q};
    s_w    = {1'b0, s_n};
    sum_w  = p_w + s_w;
    diff_w = p_w - s_w;
    is_up  = (p_w >= UP_LO) && (p_w <= UP_HI);
    is_lo  = (p_w >= LO_LO) && (p_w <= LO_HI);
    dout_d = s2_p_q;
    if (is_up || is_lo) begin
      case (s2_dir_q)
        2'b10: begin
          if ((is_up && diff_w < UP_LO) || (is_lo && diff_w < LO_LO))
            dout_d = s2_p_q - s_n + WRAP;
          else
            dout_d = s2_p_q - s_n;
        end
        2'b01: begin
          if ((is_up && sum_w > UP_HI) || (is_lo && sum_w > LO_HI))
            dout_d = s2_p_q + s_n - WRAP;
          else
            dout_d = s2_p_q + s_n;
        end
        default: dout_d = s2_p_q;
      endcase
    end
  end

  // Pipeline: valids advance every cycle, payloads load only with their valid so dout holds.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_dir_q <= 2'b00;
      s1_sh_q  <= 5'd0;
      s2_v_q   <= 1'b0;
      s2_p_q   <= '0;
      s2_dir_q <= 2'b00;
      s2_sh_q  <= 5'd0;
      v_q      <= 1'b0;
      dout_q   <= '0;
    end else begin
      s1_v_q <= bus.vin;
      if (bus.vin) begin
        s1_x_q   <= bus.din ^ key;
        s1_dir_q <= bus.direction;
        s1_sh_q  <= sh_mod;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_p_q   <= perm;
        s2_dir_q <= s1_dir_q;
        s2_sh_q  <= s1_sh_q;
      end
      v_q <= s2_v_q;
      if (s2_v_q) dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.v    = v_q;

`ifdef DECRYPT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating delivered-byte count; advances on the same edge that raises v.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)                         cnt_q <= '0;
    else if (s2_v_q && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.byte_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_decryption.sv
// tb/tb_decryption.sv - directed self-checking bench for decryption
module tb_decryption;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decryption_if bus ();

  decryption dut (
    .clock (clk),
    .rst   (rst_n),
    .bus   (bus)
  );

  // din, direction, shift, expected plaintext (all sent with key index 0)
  logic [7:0] sv_din [11] = '{8'hAF, 8'hAF, 8'hAF, 8'hAF, 8'hAF, 8'hAF, 8'hEE, 8'h29, 8'h69, 8'h7E, 8'hEE};
  logic [1:0] sv_dir [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [4:0] sv_sh  [11] = '{5'd3,  5'd29, 5'd31, 5'd26, 5'd2,  5'd5,  5'd1,  5'd1,  5'd1,  5'd1,  5'd3};
  logic [7:0] sv_exp [11] = '{8'h5A, 8'h5A, 8'h58, 8'h43, 8'h45, 8'h43, 8'h7A, 8'h41, 8'h61, 8'h20, 8'h64};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vin, input logic [7:0] din, input logic [1:0] dir,
                       input logic [4:0] sh, input logic rs);
    bus.vin       = vin;
    bus.din       = din;
    bus.direction = dir;
    bus.shift     = sh;
    bus.resync    = rs;
  endtask

  task automatic idle;
    drive(1'b0, 8'h00, 2'b00, 5'd0, 1'b0);
  endtask

  task automatic do_resync;
    drive(1'b0, 8'h00, 2'b00, 5'd0, 1'b1);
    tick();
    idle();
  endtask

  task automatic one_byte(input logic [7:0] din, input logic [1:0] dir, input logic [4:0] sh,
                          input logic rs, output logic [7:0] got, output int lat, output int pulses);
    drive(1'b1, din, dir, sh, rs);
    lat    = -1;
    pulses = 0;
    got    = 8'h00;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) drive(1'b0, 8'hFF, ~dir, 5'd0, 1'b0);
      if (bus.v === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          got = bus.dout;
        end
      end
    end
    idle();
  endtask

  task automatic test_reset;
    int vcount;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.v !== 1'b0) begin errors++; $display("FAIL reset_v: v=%b expected 0", bus.v); end
    checks++;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: dout=%h expected 00", bus.dout); end
`ifdef DECRYPT_CNT_EN
    checks++;
    if (bus.byte_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: byte_cnt=%0d expected 0", bus.byte_cnt); end
`endif
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.v !== 1'b0) vcount++;
    end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL reset_release_v: v-high cycles=%0d expected 0", vcount); end
  endtask

  task automatic test_basic;
    logic [7:0] got;
    int lat, pulses;
    one_byte(8'hAE, 2'b00, 5'd0, 1'b0, got, lat, pulses);
    checks++;
    if (got !== 8'h41) begin errors++; $display("FAIL basic_dout: dout=%h expected 41", got); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL basic_latency: latency=%0d expected 3", lat); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL basic_pulse: v-high cycles=%0d expected 1", pulses); end
    checks++;
    if (bus.dout !== 8'h41) begin errors++; $display("FAIL basic_hold: dout=%h expected 41", bus.dout); end
`ifdef DECRYPT_CNT_EN
    checks++;
    if (bus.byte_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: byte_cnt=%0d expected 1", bus.byte_cnt); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic       exp_v [7];
    bytes = '{8'hAE, 8'hD9, 8'hEE};
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, bytes[0], 2'b00, 5'd0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c < 3) drive(1'b1, bytes[c], 2'b00, 5'd0, 1'b0);
      else       idle();
      checks++;
      if (bus.v !== exp_v[c]) begin
        errors++;
        $display("FAIL b2b_v[%0d]: v=%b expected %b", c, bus.v, exp_v[c]);
      end
      if (exp_v[c]) begin
        checks++;
        if (bus.dout !== 8'h41) begin
          errors++;
          $display("FAIL b2b_dout[%0d]: dout=%h expected 41", c, bus.dout);
        end
      end
    end
`ifdef DECRYPT_CNT_EN
    checks++;
    if (bus.byte_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt: byte_cnt=%0d expected 3", bus.byte_cnt); end
`endif
  endtask

  task automatic test_shift;
    logic [7:0] got;
    int lat, pulses;
    for (int i = 0; i < 11; i++) begin
      do_resync();
      one_byte(sv_din[i], sv_dir[i], sv_sh[i], 1'b0, got, lat, pulses);
      checks++;
      if (got !== sv_exp[i] || lat !== 3) begin
        errors++;
        $display("FAIL shift_vec%0d: dout=%h latency=%0d expected %h latency 3", i, got, lat, sv_exp[i]);
      end
    end
  endtask

  task automatic test_resync;
    logic [7:0] got;
    logic [7:0] r_din [5];
    logic       r_rs  [5];
    int lat, pulses;
    r_din = '{8'hAE, 8'hAE, 8'hD9, 8'hEE, 8'hAE};
    r_rs  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_resync();
    for (int i = 0; i < 5; i++) begin
      one_byte(r_din[i], 2'b00, 5'd0, r_rs[i], got, lat, pulses);
      checks++;
      if (got !== 8'h41) begin
        errors++;
        $display("FAIL resync_byte%0d: dout=%h expected 41", i, got);
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] got;
    int lat, pulses, vcount;
    do_resync();
    drive(1'b1, 8'hAE, 2'b00, 5'd0, 1'b0);
    tick();
    drive(1'b1, 8'hD9, 2'b00, 5'd0, 1'b0);
    tick();
    drive(1'b1, 8'hEE, 2'b00, 5'd0, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.v !== 1'b1) begin errors++; $display("FAIL mid_pre_v: v=%b expected 1", bus.v); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.v !== 1'b0) begin errors++; $display("FAIL mid_async_v: v=%b expected 0", bus.v); end
    checks++;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL mid_async_dout: dout=%h expected 00", bus.dout); end
`ifdef DECRYPT_CNT_EN
    checks++;
    if (bus.byte_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: byte_cnt=%0d expected 0", bus.byte_cnt); end
`endif
    tick();
    tick();
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.v !== 1'b0) vcount++;
    end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL mid_late_v: v-high cycles=%0d expected 0", vcount); end
    one_byte(8'hAE, 2'b00, 5'd0, 1'b0, got, lat, pulses);
    checks++;
    if (got !== 8'h41 || lat !== 3) begin
      errors++;
      $display("FAIL mid_after: dout=%h latency=%0d expected 41 latency 3", got, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_shift();
    test_resync();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
